// File: rtl/spi_slave_byte.sv
// spi_slave_byte
// Byte-oriented SPI slave running in the sys_clk domain. sclk, n_cs and mosi
// are oversampled through synchronizers. Received bytes go to a FIFO write
// port, and transmit bytes come from a show-ahead FIFO read port.
//
// Ports:
//   sys_clk, n_rst      system clock (rising edge), async active-low reset
//   sclk, n_cs, mosi    SPI pins from the master (asynchronous)
//   miso, miso_oe       serial data to the master, MSB first, and its enable
//   tx_data, tx_empty   TX FIFO head and empty flag
//   tx_rdreq            one-cycle TX FIFO pop
//   rx_data, rx_wrreq   received byte and its one-cycle write strobe
//   frame_active        high while a frame is in progress
//   frame_err           one-cycle pulse on a partial byte or a TX underrun
//
// state  | meaning
// IDLE   | no frame; waiting for an armed n_cs fall
// ACTIVE | frame in progress; sample/shift on sclk edges
module spi_slave_byte #(
    parameter bit         CPOL        = 1'b1,
    parameter bit         CPHA        = 1'b0,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       sys_clk,
    input  logic       n_rst,
    input  logic       sclk,
    input  logic       n_cs,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_empty,
    output logic       tx_rdreq,
    output logic [7:0] rx_data,
    output logic       rx_wrreq,
    output logic       frame_active,
    output logic       frame_err
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t r_state, w_next_state;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
    logic                   r_sclk_d, r_cs_d;
    logic [SYNC_STAGES:0]   r_warm;
    logic                   r_armed;
    logic [7:0]             r_tx_reg;
    logic [6:0]             r_rx_shift;
    logic [2:0]             r_rx_cnt;
    logic                   r_byte_done;
    logic [7:0]             r_rx_data;
    logic                   r_rx_wrreq, r_tx_rdreq, r_frame_err;

    logic w_sclk_s, w_cs_s, w_mosi_s;
    logic w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic w_leading, w_trailing, w_sample_edge, w_shift_edge;
    logic w_start, w_end, w_sample, w_shift, w_load;

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    assign w_sclk_rise = ~r_sclk_d & w_sclk_s;
    assign w_sclk_fall = r_sclk_d & ~w_sclk_s;
    assign w_cs_rise   = ~r_cs_d & w_cs_s;
    assign w_cs_fall   = r_cs_d & ~w_cs_s;

    assign w_leading     = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trailing    = CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_sample_edge = CPHA ? w_trailing : w_leading;
    assign w_shift_edge  = CPHA ? w_leading : w_trailing;

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sclk_sync <= {SYNC_STAGES{CPOL}};
            r_cs_sync   <= {SYNC_STAGES{1'b1}};
            r_mosi_sync <= '0;
            r_sclk_d    <= CPOL;
            r_cs_d      <= 1'b1;
            r_warm      <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], n_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
            r_cs_d      <= w_cs_s;
            r_warm      <= {r_warm[SYNC_STAGES-1:0], 1'b1};
            // The chains reset to n_cs high, so only trust a high level once
            // every stage holds a real pin sample; this keeps n_cs held low
            // through reset release from looking like a fresh fall.
            if (r_warm[SYNC_STAGES] && w_cs_s && r_cs_d)
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // n_cs edges take priority over any sclk edge detected in the same cycle.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_end        = 1'b0;
        w_sample     = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall && r_armed) begin
                    w_next_state = ACTIVE;
                    w_start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_cs_rise) begin
                    w_next_state = IDLE;
                    w_end        = 1'b1;
                end else if (w_sample_edge) begin
                    w_sample = 1'b1;
                end else if (w_shift_edge) begin
                    w_shift = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_load = w_start | (w_shift & r_byte_done);

    always_ff @(posedge sys_clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tx_reg    <= '0;
            r_rx_shift  <= '0;
            r_rx_cnt    <= '0;
            r_byte_done <= 1'b0;
            r_rx_data   <= '0;
            r_rx_wrreq  <= 1'b0;
            r_tx_rdreq  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_wrreq  <= 1'b0;
            r_tx_rdreq  <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_load) begin
                if (tx_empty) begin
                    r_tx_reg    <= IDLE_BYTE;
                    r_frame_err <= 1'b1;
                end else begin
                    r_tx_reg   <= tx_data;
                    r_tx_rdreq <= 1'b1;
                end
            end
            if (w_start) begin
                r_rx_cnt    <= '0;
                r_byte_done <= 1'b0;
                r_rx_shift  <= '0;
            end
            if (w_end && r_rx_cnt != 3'd0)
                r_frame_err <= 1'b1;
            if (w_sample) begin
                r_rx_shift <= {r_rx_shift[5:0], w_mosi_s};
                r_rx_cnt   <= r_rx_cnt + 3'd1;
                if (r_rx_cnt == 3'd7) begin
                    r_rx_data   <= {r_rx_shift, w_mosi_s};
                    r_rx_wrreq  <= 1'b1;
                    r_byte_done <= 1'b1;
                end
            end
            // With rx_cnt at 0 and no byte pending, bit 7 is already on miso
            // (first leading edge when CPHA=1), so hold.
            if (w_shift) begin
                if (r_byte_done)
                    r_byte_done <= 1'b0;
                else if (r_rx_cnt != 3'd0)
                    r_tx_reg <= {r_tx_reg[6:0], 1'b0};
            end
        end
    end

    assign frame_active = (r_state == ACTIVE);
    assign miso         = frame_active ? r_tx_reg[7] : 1'b0;
    assign miso_oe      = frame_active;
    assign tx_rdreq     = r_tx_rdreq;
    assign rx_data      = r_rx_data;
    assign rx_wrreq     = r_rx_wrreq;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_spi_slave_byte.sv
// tb_spi_slave_byte
// Directed bench for spi_slave_byte. Three instances cover mode 0 (index 0),
// mode 1 (index 1) and mode 3 (index 2); each has its own sclk, n_cs and a
// small show-ahead TX FIFO model. mosi is shared since one frame runs at a time.
module tb_spi_slave_byte;

    localparam int H = 8;   // sys_clk cycles per sclk phase
    localparam logic [2:0] M_CPOL = 3'b100;
    localparam logic [2:0] M_CPHA = 3'b110;

    logic       sys_clk = 1'b0;
    logic       n_rst;
    logic       mosi;
    logic [2:0] sclk, n_cs, miso, miso_oe, tx_empty, tx_rdreq;
    logic [2:0] rx_wrreq, frame_active, frame_err;
    logic [7:0] tx_data [3];
    logic [7:0] rx_data [3];

    logic [7:0] tx_mem [3][8];
    int         tx_wr [3] = '{default: 0};
    int         tx_rd [3] = '{default: 0};
    int         rx_n  [3] = '{default: 0};
    int         rd_n  [3] = '{default: 0};
    int         err_n [3] = '{default: 0};
    logic [7:0] rx_log [3][16];

    int n_chk = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    spi_slave_byte #(.CPOL(1'b0), .CPHA(1'b0)) u_m0 (
        .sys_clk(sys_clk), .n_rst(n_rst), .sclk(sclk[0]), .n_cs(n_cs[0]), .mosi(mosi),
        .miso(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data[0]), .tx_empty(tx_empty[0]),
        .tx_rdreq(tx_rdreq[0]), .rx_data(rx_data[0]), .rx_wrreq(rx_wrreq[0]),
        .frame_active(frame_active[0]), .frame_err(frame_err[0]));

    spi_slave_byte #(.CPOL(1'b0), .CPHA(1'b1)) u_m1 (
        .sys_clk(sys_clk), .n_rst(n_rst), .sclk(sclk[1]), .n_cs(n_cs[1]), .mosi(mosi),
        .miso(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data[1]), .tx_empty(tx_empty[1]),
        .tx_rdreq(tx_rdreq[1]), .rx_data(rx_data[1]), .rx_wrreq(rx_wrreq[1]),
        .frame_active(frame_active[1]), .frame_err(frame_err[1]));

    spi_slave_byte #(.CPOL(1'b1), .CPHA(1'b1)) u_m3 (
        .sys_clk(sys_clk), .n_rst(n_rst), .sclk(sclk[2]), .n_cs(n_cs[2]), .mosi(mosi),
        .miso(miso[2]), .miso_oe(miso_oe[2]), .tx_data(tx_data[2]), .tx_empty(tx_empty[2]),
        .tx_rdreq(tx_rdreq[2]), .rx_data(rx_data[2]), .rx_wrreq(rx_wrreq[2]),
        .frame_active(frame_active[2]), .frame_err(frame_err[2]));

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tx_empty[i] = (tx_rd[i] == tx_wr[i]);
            tx_data[i]  = tx_mem[i][tx_rd[i] % 8];
        end
    end

    always @(posedge sys_clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rx_wrreq[i]) begin
                rx_log[i][rx_n[i] % 16] <= rx_data[i];
                rx_n[i] <= rx_n[i] + 1;
            end
            if (tx_rdreq[i]) begin
                rd_n[i]  <= rd_n[i] + 1;
                tx_rd[i] <= tx_rd[i] + 1;
            end
            if (frame_err[i])
                err_n[i] <= err_n[i] + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int d, input logic [7:0] b);
        tx_mem[d][tx_wr[d] % 8] = b;
        tx_wr[d] = tx_wr[d] + 1;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic cs_low(input int d);
        n_cs[d] = 1'b0;
        wait_clk(2 * H);
    endtask

    task automatic cs_high(input int d);
        wait_clk(H);
        n_cs[d] = 1'b1;
        wait_clk(2 * H);
    endtask

    // Master side: drives nbits of mo MSB first and captures miso at the
    // master's sample edge.
    task automatic xfer(input int d, input int nbits, input logic [7:0] mo, output logic [7:0] mi);
        logic pol, pha;
        pol = M_CPOL[d];
        pha = M_CPHA[d];
        mi  = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            if (!pha) begin
                mosi = mo[7-b];
                wait_clk(H);
                sclk[d] = ~pol;
                mi[7-b] = miso[d];
                wait_clk(H);
                sclk[d] = pol;
            end else begin
                sclk[d] = ~pol;
                mosi = mo[7-b];
                wait_clk(H);
                sclk[d] = pol;
                mi[7-b] = miso[d];
                wait_clk(H);
            end
        end
    endtask

    initial begin
        logic [7:0] cap, c0, c1, c2;
        int b_rx, b_rd, b_err;

        n_rst = 1'b0;
        mosi  = 1'b0;
        sclk  = 3'b100;
        n_cs  = 3'b111;
        wait_clk(4);
        check_val("rst_frame_active", {29'd0, frame_active}, 32'd0);
        check_val("rst_rx_data_m3", {24'd0, rx_data[2]}, 32'd0);
        n_rst = 1'b1;
        wait_clk(10);
        check_val("idle_miso", {29'd0, miso}, 32'd0);
        check_val("idle_miso_oe", {29'd0, miso_oe}, 32'd0);
        check_val("idle_tx_rdreq", {29'd0, tx_rdreq}, 32'd0);
        check_val("idle_rx_wrreq", {29'd0, rx_wrreq}, 32'd0);
        check_val("idle_frame_err", {29'd0, frame_err}, 32'd0);
        check_val("idle_rx_data_m0", {24'd0, rx_data[0]}, 32'd0);

        // Mode 0, one byte: TX A5, master sends 3C.
        push(0, 8'hA5);
        b_rx = rx_n[0]; b_rd = rd_n[0]; b_err = err_n[0];
        cs_low(0);
        check_val("m0_frame_active", {31'd0, frame_active[0]}, 32'd1);
        check_val("m0_miso_oe", {31'd0, miso_oe[0]}, 32'd1);
        xfer(0, 8, 8'h3C, cap);
        check_val("m0_err_in_byte", err_n[0] - b_err, 0);
        wait_clk(H);
        check_val("m0_miso_byte", {24'd0, cap}, 32'hA5);
        check_val("m0_rx_count", rx_n[0] - b_rx, 1);
        check_val("m0_rx_data", {24'd0, rx_log[0][b_rx % 16]}, 32'h3C);
        check_val("m0_rdreq_count", rd_n[0] - b_rd, 1);
        // The final trailing edge reloads from an empty FIFO: one underrun.
        check_val("m0_reload_underrun", err_n[0] - b_err, 1);
        cs_high(0);
        check_val("m0_end_active", {31'd0, frame_active[0]}, 32'd0);
        check_val("m0_end_miso_oe", {31'd0, miso_oe[0]}, 32'd0);
        check_val("m0_end_miso", {31'd0, miso[0]}, 32'd0);
        check_val("m0_end_err", err_n[0] - b_err, 1);

        // Mode 3, three bytes.
        push(2, 8'h01); push(2, 8'h80); push(2, 8'hFF);
        b_rx = rx_n[2]; b_rd = rd_n[2]; b_err = err_n[2];
        cs_low(2);
        xfer(2, 8, 8'h12, c0);
        xfer(2, 8, 8'h34, c1);
        xfer(2, 8, 8'h56, c2);
        wait_clk(H);
        check_val("m3_miso_b0", {24'd0, c0}, 32'h01);
        check_val("m3_miso_b1", {24'd0, c1}, 32'h80);
        check_val("m3_miso_b2", {24'd0, c2}, 32'hFF);
        check_val("m3_rx_count", rx_n[2] - b_rx, 3);
        check_val("m3_rx_b0", {24'd0, rx_log[2][b_rx % 16]}, 32'h12);
        check_val("m3_rx_b1", {24'd0, rx_log[2][(b_rx + 1) % 16]}, 32'h34);
        check_val("m3_rx_b2", {24'd0, rx_log[2][(b_rx + 2) % 16]}, 32'h56);
        check_val("m3_rdreq_count", rd_n[2] - b_rd, 3);
        cs_high(2);
        check_val("m3_err_count", err_n[2] - b_err, 0);
        check_val("m3_end_active", {31'd0, frame_active[2]}, 32'd0);

        // Mode 1 with an empty TX FIFO.
        b_rx = rx_n[1]; b_rd = rd_n[1]; b_err = err_n[1];
        cs_low(1);
        check_val("m1_start_underrun", err_n[1] - b_err, 1);
        xfer(1, 8, 8'h5A, cap);
        cs_high(1);
        check_val("m1_miso_idle_byte", {24'd0, cap}, 32'hFF);
        check_val("m1_err_count", err_n[1] - b_err, 1);
        check_val("m1_rdreq_count", rd_n[1] - b_rd, 0);
        check_val("m1_rx_data", {24'd0, rx_log[1][b_rx % 16]}, 32'h5A);

        // Mode 0, n_cs rises after 5 bits.
        push(0, 8'hC3);
        b_rx = rx_n[0]; b_rd = rd_n[0]; b_err = err_n[0];
        cs_low(0);
        xfer(0, 5, 8'hF0, cap);
        cs_high(0);
        check_val("part_miso_bits", {24'd0, cap}, 32'hC0);
        check_val("part_rx_count", rx_n[0] - b_rx, 0);
        check_val("part_err_count", err_n[0] - b_err, 1);
        check_val("part_rdreq_count", rd_n[0] - b_rd, 1);
        check_val("part_active", {31'd0, frame_active[0]}, 32'd0);
        check_val("part_miso_oe", {31'd0, miso_oe[0]}, 32'd0);

        // Mode 3, reset at bit 4 of byte 2 with n_cs held low.
        push(2, 8'h11); push(2, 8'h22); push(2, 8'h33);
        b_rx = rx_n[2];
        cs_low(2);
        xfer(2, 8, 8'hAA, c0);
        xfer(2, 4, 8'hBB, c1);
        check_val("rst_pre_miso", {24'd0, c0}, 32'h11);
        check_val("rst_pre_rx", {24'd0, rx_log[2][b_rx % 16]}, 32'hAA);
        n_rst = 1'b0;
        wait_clk(2);
        check_val("rstmid_active", {31'd0, frame_active[2]}, 32'd0);
        check_val("rstmid_miso_oe", {31'd0, miso_oe[2]}, 32'd0);
        check_val("rstmid_miso", {31'd0, miso[2]}, 32'd0);
        check_val("rstmid_rx_data", {24'd0, rx_data[2]}, 32'd0);
        n_rst = 1'b1;
        wait_clk(2 * H);
        b_rx = rx_n[2]; b_rd = rd_n[2];
        xfer(2, 8, 8'hE7, cap);
        wait_clk(H);
        check_val("rstmid_quiet_active", {31'd0, frame_active[2]}, 32'd0);
        check_val("rstmid_quiet_rx", rx_n[2] - b_rx, 0);
        check_val("rstmid_quiet_rd", rd_n[2] - b_rd, 0);
        n_cs[2] = 1'b1;
        wait_clk(2 * H);
        cs_low(2);
        check_val("rstmid_new_active", {31'd0, frame_active[2]}, 32'd1);
        xfer(2, 8, 8'h69, cap);
        cs_high(2);
        check_val("rstmid_new_miso", {24'd0, cap}, 32'h33);
        check_val("rstmid_new_rx_count", rx_n[2] - b_rx, 1);
        check_val("rstmid_new_rx", {24'd0, rx_log[2][b_rx % 16]}, 32'h69);

        // Mode 1, n_cs rises together with the 8th sample edge.
        push(1, 8'h77);
        b_rx = rx_n[1]; b_rd = rd_n[1]; b_err = err_n[1];
        cs_low(1);
        xfer(1, 7, 8'hFE, cap);
        sclk[1] = 1'b1;
        mosi    = 1'b0;
        wait_clk(H);
        sclk[1] = 1'b0;
        n_cs[1] = 1'b1;
        wait_clk(2 * H);
        check_val("coin_rx_count", rx_n[1] - b_rx, 0);
        check_val("coin_err_count", err_n[1] - b_err, 1);
        check_val("coin_rdreq_count", rd_n[1] - b_rd, 1);
        check_val("coin_active", {31'd0, frame_active[1]}, 32'd0);
        check_val("coin_miso_bits", {24'd0, cap}, 32'h76);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
